apb_master: RTL and testbench
=============================

# apb_master

Bridges the multi-cycle RV32I core's memory port (`transfer`, `busWe`, address/data) onto an APB-style peripheral bus shared by RAM, GPIO and UART. It sequences each CPU request through SETUP and ACCESS phases and decodes the address to a one-hot slave select. It returns a single-cycle `ready` pulse that releases the core's S_MEM/L_MEM wait state, plus a registered read word for the core's write-back cycle. It also bounds stalls with a timeout and flags unmapped or timed-out accesses.

## Interface
- `NUM_SLAVES`, 4 — number of APB slots. Slot 0 RAM, 1 GPIO, 2 UART, 3 spare.
- `TIMEOUT`, 255 — maximum ACCESS cycles before forced completion. Counter width is `$clog2(TIMEOUT+1)`.

- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-high.
- `transfer` in 1 — CPU request; held high until `ready`.
- `busWe` in 1 — 1 = write, 0 = read; sampled with `transfer`.
- `busAddr` in 32 — byte address.
- `busWData` in 32 — write data.
- `busRData` out 32 — registered read data.
- `ready` out 1 — completion pulse.
- `busErr` out 1 — error pulse, coincident with `ready`.
- `PADDR` out 32, `PWDATA` out 32, `PWRITE` out 1, `PENABLE` out 1 — APB request.
- `PSEL` out NUM_SLAVES — one-hot slave select.
- `PRDATA` in 32·NUM_SLAVES — slot i at bits [32i+31:32i].
- `PREADY` in NUM_SLAVES — per-slot ready.

## Operation
- States: IDLE, SETUP, ACCESS.
- **IDLE**
  - `transfer=1`: latch `busAddr`→`PADDR`, `busWData`→`PWDATA`, `busWe`→`PWRITE`; latch decoded slot; go to SETUP.
  - Otherwise stay in IDLE.
- **Decode**
  - `busAddr[31:16]==16'h1000` and `busAddr[15:12]<NUM_SLAVES` → slot `busAddr[15:12]`.
  - Anything else → unmapped.
- **SETUP**
  - `PSEL[slot]=1`, `PENABLE=0`; unmapped → `PSEL` all zero.
  - Unconditionally go to ACCESS; clear timeout counter.
- **ACCESS**
  - `PSEL` held, `PENABLE=1`.
  - Completion, checked in priority order:
    - (a) unmapped → `ready=1`, `busErr=1`, `busRData`←0 on read.
    - (b) `PREADY[slot]=1` → `ready=1`; read: `busRData`←`PRDATA[slot]` at this edge.
    - (c) counter == TIMEOUT−1 → `ready=1`, `busErr=1`, `busRData`←0 on read.
    - Otherwise increment counter and stay.
  - On completion go to IDLE.
- Writes never modify `busRData`. `busRData` holds until the next completed read.
- `PADDR`/`PWDATA`/`PWRITE` remain stable from SETUP until the next IDLE latch.
- `PREADY` of non-selected slots is ignored.

## Timing
- Reset (async, immediate): state IDLE; `PSEL`=0, `PENABLE`=0, `PADDR`=0, `PWDATA`=0, `PWRITE`=0, `busRData`=0, timeout counter=0. `ready`/`busErr`=0 because they decode only from ACCESS.
- `ready` and `busErr` are combinational from state ACCESS and `PREADY`/counter. They are high exactly one cycle per transaction.
- Minimum latency: `transfer` sampled in cycle 0 (IDLE), SETUP in cycle 1, ACCESS with `ready` in cycle 2. `busRData` is valid from cycle 3, matching the core's L_WB.
- Each wait cycle with `PREADY=0` adds one cycle. Timeout `ready` falls in ACCESS cycle TIMEOUT (1-based).
- The cycle after `ready` is always IDLE. A `transfer` high in that cycle starts a new transaction, giving a 3-cycle back-to-back period.
- `transfer` dropping mid-transaction is ignored; the transaction completes.
- Reset asserted during SETUP/ACCESS aborts the transaction. No `ready` is issued and `PSEL` drops asynchronously.

## Structure
- Shared package `bus_pkg` holds:
  - `apb_state_e` (IDLE, SETUP, ACCESS);
  - `BUS_BASE_HI = 16'h1000`;
  - slot indices `SLOT_RAM = 0`, `SLOT_GPIO = 1`, `SLOT_UART = 2`.
- Sub-module `apb_addr_decoder`: purely combinational. Takes `addr`, returns `slot` index and `mapped` flag; parameterized by `NUM_SLAVES`.
- The FSM, timeout counter, request latches and read-data mux/register live in `apb_master`.

## Test plan
- Read, zero wait: `busAddr=0x1000_2004`, UART `PREADY=1`, `PRDATA=0xDEAD_BEEF` → `PSEL=4'b0100` in cycles 1–2, `PENABLE` in cycle 2, `ready` in cycle 2. `busRData=0xDEAD_BEEF` from cycle 3 and holds through a following write.
- Write with 3 wait states: `busAddr=0x1000_1000`, `busWData=0x0000_00A5`, GPIO `PREADY` low for 3 ACCESS cycles → `PWRITE=1`, `PWDATA=0xA5` stable. `ready` in cycle 5, `busErr=0`, `busRData` unchanged.
- Unmapped: `busAddr=0x2000_0000` read → `PSEL=0` throughout, `ready=1` and `busErr=1` in cycle 2, `busRData=0` from cycle 3.
- Timeout with `TIMEOUT=4`: RAM `PREADY` stuck at 0 → `ready=1` and `busErr=1` in ACCESS cycle 4 (cycle 5 overall), then IDLE.
- Back-to-back and reset: two reads issued on the cycle after each `ready` → `ready` in cycles 2 and 5. A third transfer with `reset` pulsed during ACCESS → all outputs zero immediately, no `ready`, state IDLE after reset release.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions: APB FSM states, peripheral window base and slot map.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Upper half of every peripheral address
    localparam logic [15:0] BUS_BASE_HI = 16'h1000;

    localparam int SLOT_RAM  = 0;
    localparam int SLOT_GPIO = 1;
    localparam int SLOT_UART = 2;

    // Width of a slot index; a single-slot bus still needs one bit
    function automatic int slot_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: peripheral window 0x1000_xxxx, 4 KiB per slot.
module apb_addr_decoder
    import bus_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int SLOT_W     = slot_width(NUM_SLAVES)
) (
    input  logic [31:0]       addr,
    output logic [SLOT_W-1:0] slot,
    output logic              mapped
);

    // Slot comes from address bits [15:12]; only valid inside the window and below NUM_SLAVES
    always_comb begin
        slot   = SLOT_W'(addr[15:12]);
        mapped = 1'b0;
        if ((addr[31:16] == BUS_BASE_HI) && ({28'd0, addr[15:12]} < 32'(NUM_SLAVES))) begin
            mapped = 1'b1;
        end else begin
            mapped = 1'b0;
        end
    end

endmodule

// File: rtl/apb_master.sv
// CPU memory port to APB bridge: SETUP/ACCESS sequencing, slot select,
// single-cycle ready/error pulse, registered read data, bounded stall.
module apb_master
    import bus_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     transfer,
    input  logic                     busWe,
    input  logic [31:0]              busAddr,
    input  logic [31:0]              busWData,
    output logic [31:0]              busRData,
    output logic                     ready,
    output logic                     busErr,
    output logic [31:0]              PADDR,
    output logic [31:0]              PWDATA,
    output logic                     PWRITE,
    output logic                     PENABLE,
    output logic [NUM_SLAVES-1:0]    PSEL,
    input  logic [32*NUM_SLAVES-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]    PREADY
);

    localparam int SLOT_W = slot_width(NUM_SLAVES);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    apb_state_e          state_r;
    apb_state_e          next_state_s;
    logic [SLOT_W-1:0]   dec_slot_s;
    logic                dec_mapped_s;
    logic [SLOT_W-1:0]   slot_r;
    logic                mapped_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [31:0]         paddr_r;
    logic [31:0]         pwdata_r;
    logic                pwrite_r;
    logic [31:0]         rdata_r;
    logic                sel_pready_s;
    logic [31:0]         sel_prdata_s;
    logic                timeout_hit_s;
    logic                ready_s;
    logic                err_s;
    logic [NUM_SLAVES-1:0] psel_s;
    logic                penable_s;

    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLOT_W     (SLOT_W)
    ) u_decoder (
        .addr   (busAddr),
        .slot   (dec_slot_s),
        .mapped (dec_mapped_s)
    );

    // Pick the ready/data lines of the latched slot; other slots are ignored
    always_comb begin
        sel_pready_s = 1'b0;
        sel_prdata_s = 32'd0;
        if (mapped_r) begin
            sel_pready_s = PREADY[slot_r];
            sel_prdata_s = PRDATA[32*int'(slot_r) +: 32];
        end else begin
            sel_pready_s = 1'b0;
            sel_prdata_s = 32'd0;
        end
    end

    assign timeout_hit_s = (cnt_r == CNT_W'(TIMEOUT - 1));

    // Completion decode in ACCESS: unmapped, then slave ready, then timeout
    always_comb begin
        ready_s = 1'b0;
        err_s   = 1'b0;
        if (state_r == ACCESS) begin
            if (!mapped_r) begin
                ready_s = 1'b1;
                err_s   = 1'b1;
            end else if (sel_pready_s) begin
                ready_s = 1'b1;
                err_s   = 1'b0;
            end else if (timeout_hit_s) begin
                ready_s = 1'b1;
                err_s   = 1'b1;
            end else begin
                ready_s = 1'b0;
                err_s   = 1'b0;
            end
        end else begin
            ready_s = 1'b0;
            err_s   = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    next_state_s = transfer ? SETUP : IDLE;
            SETUP:   next_state_s = ACCESS;
            ACCESS:  next_state_s = ready_s ? IDLE : ACCESS;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM outputs: select held through SETUP and ACCESS, enable only in ACCESS
    always_comb begin
        psel_s    = '0;
        penable_s = 1'b0;
        case (state_r)
            SETUP: begin
                if (mapped_r) begin
                    psel_s[slot_r] = 1'b1;
                end else begin
                    psel_s = '0;
                end
                penable_s = 1'b0;
            end
            ACCESS: begin
                if (mapped_r) begin
                    psel_s[slot_r] = 1'b1;
                end else begin
                    psel_s = '0;
                end
                penable_s = 1'b1;
            end
            default: begin
                psel_s    = '0;
                penable_s = 1'b0;
            end
        endcase
    end

    // Request latches, wait counter and read-data register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            paddr_r  <= 32'd0;
            pwdata_r <= 32'd0;
            pwrite_r <= 1'b0;
            slot_r   <= '0;
            mapped_r <= 1'b0;
            cnt_r    <= '0;
            rdata_r  <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (transfer) begin
                        paddr_r  <= busAddr;
                        pwdata_r <= busWData;
                        pwrite_r <= busWe;
                        slot_r   <= dec_slot_s;
                        mapped_r <= dec_mapped_s;
                    end
                end
                SETUP: begin
                    cnt_r <= '0;
                end
                ACCESS: begin
                    if (ready_s) begin
                        // Errored reads return zero; writes leave the read word alone
                        if (!pwrite_r) begin
                            rdata_r <= err_s ? 32'd0 : sel_prdata_s;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign busRData = rdata_r;
    assign ready    = ready_s;
    assign busErr   = err_s;
    assign PADDR    = paddr_r;
    assign PWDATA   = pwdata_r;
    assign PWRITE   = pwrite_r;
    assign PENABLE  = penable_s;
    assign PSEL     = psel_s;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: per-cycle vector table plus reset/recovery sequences.
module tb_apb_master;

    localparam logic [31:0] AA  = 32'h1000_2004; // UART
    localparam logic [31:0] AB  = 32'h1000_1000; // GPIO
    localparam logic [31:0] AC  = 32'h2000_0000; // outside window
    localparam logic [31:0] AE1 = 32'h1000_0010; // RAM
    localparam logic [31:0] AE2 = 32'h1000_1FFC; // GPIO
    localparam logic [31:0] AF  = 32'h1000_4000; // slot 4, not present
    localparam logic [31:0] AD  = 32'h1000_0008; // RAM
    localparam logic [31:0] D_RAM  = 32'h1111_1111;
    localparam logic [31:0] D_GPIO = 32'h2222_2222;
    localparam logic [31:0] D_UART = 32'hDEAD_BEEF;
    localparam logic [31:0] D_SPR  = 32'h3333_3333;

    logic         clk;
    logic         reset;
    logic         transfer;
    logic         busWe;
    logic [31:0]  busAddr;
    logic [31:0]  busWData;
    logic [31:0]  busRData;
    logic         ready;
    logic         busErr;
    logic [31:0]  PADDR;
    logic [31:0]  PWDATA;
    logic         PWRITE;
    logic         PENABLE;
    logic [3:0]   PSEL;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY;

    int checks;
    int failures;

    typedef struct {
        logic        tr;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  prdy;
        logic [3:0]  psel;
        logic        pen;
        logic        rdy;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] paddr;
        logic        pwr;
        logic [31:0] pwd;
    } vec_t;

    vec_t vecs[$];

    apb_master #(
        .NUM_SLAVES (4),
        .TIMEOUT    (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .transfer (transfer),
        .busWe    (busWe),
        .busAddr  (busAddr),
        .busWData (busWData),
        .busRData (busRData),
        .ready    (ready),
        .busErr   (busErr),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PENABLE  (PENABLE),
        .PSEL     (PSEL),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic tr, input logic we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [3:0] prdy,
                                input logic [3:0] psel, input logic pen, input logic rdy,
                                input logic err, input logic [31:0] rdata,
                                input logic [31:0] paddr, input logic pwr,
                                input logic [31:0] pwd);
        vec_t v;
        v.tr = tr; v.we = we; v.addr = addr; v.wd = wd; v.prdy = prdy;
        v.psel = psel; v.pen = pen; v.rdy = rdy; v.err = err; v.rdata = rdata;
        v.paddr = paddr; v.pwr = pwr; v.pwd = pwd;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step%0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic tr, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] prdy);
        transfer = tr;
        busWe    = we;
        busAddr  = addr;
        busWData = wd;
        PREADY   = prdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm, input int idx);
        chk({nm, "_psel"},  idx, {28'd0, PSEL}, 32'd0);
        chk({nm, "_pen"},   idx, {31'd0, PENABLE}, 32'd0);
        chk({nm, "_paddr"}, idx, PADDR, 32'd0);
        chk({nm, "_pwdata"},idx, PWDATA, 32'd0);
        chk({nm, "_pwrite"},idx, {31'd0, PWRITE}, 32'd0);
        chk({nm, "_rdata"}, idx, busRData, 32'd0);
        chk({nm, "_ready"}, idx, {31'd0, ready}, 32'd0);
        chk({nm, "_err"},   idx, {31'd0, busErr}, 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        PRDATA   = {D_SPR, D_UART, D_GPIO, D_RAM};
        reset    = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'b0000);

        // Read UART, zero wait
        vecs.push_back(mk(1, 0, AA, 0, 4'b0100, 4'b0000, 0, 0, 0, 0,      0,  0, 0));
        vecs.push_back(mk(1, 0, AA, 0, 4'b0100, 4'b0100, 0, 0, 0, 0,      AA, 0, 0));
        vecs.push_back(mk(1, 0, AA, 0, 4'b0100, 4'b0100, 1, 1, 0, 0,      AA, 0, 0));
        // Write GPIO, 3 wait states; other slots' ready ignored; PREADY wins over timeout
        vecs.push_back(mk(1, 1, AB, 32'hA5, 4'b0000, 4'b0000, 0, 0, 0, D_UART, AA, 0, 0));
        vecs.push_back(mk(1, 1, AB, 32'hA5, 4'b0000, 4'b0010, 0, 0, 0, D_UART, AB, 1, 32'hA5));
        vecs.push_back(mk(1, 1, AB, 32'hA5, 4'b1101, 4'b0010, 1, 0, 0, D_UART, AB, 1, 32'hA5));
        vecs.push_back(mk(1, 1, AB, 32'hA5, 4'b1101, 4'b0010, 1, 0, 0, D_UART, AB, 1, 32'hA5));
        vecs.push_back(mk(1, 1, AB, 32'hA5, 4'b1101, 4'b0010, 1, 0, 0, D_UART, AB, 1, 32'hA5));
        vecs.push_back(mk(1, 1, AB, 32'hA5, 4'b0010, 4'b0010, 1, 1, 0, D_UART, AB, 1, 32'hA5));
        // Unmapped read
        vecs.push_back(mk(1, 0, AC, 0, 4'b1111, 4'b0000, 0, 0, 0, D_UART, AB, 1, 32'hA5));
        vecs.push_back(mk(1, 0, AC, 0, 4'b1111, 4'b0000, 0, 0, 0, D_UART, AC, 0, 0));
        vecs.push_back(mk(1, 0, AC, 0, 4'b1111, 4'b0000, 1, 1, 1, D_UART, AC, 0, 0));
        // Back-to-back reads RAM then GPIO
        vecs.push_back(mk(1, 0, AE1, 0, 4'b0001, 4'b0000, 0, 0, 0, 0,      AC,  0, 0));
        vecs.push_back(mk(1, 0, AE1, 0, 4'b0001, 4'b0001, 0, 0, 0, 0,      AE1, 0, 0));
        vecs.push_back(mk(1, 0, AE1, 0, 4'b0001, 4'b0001, 1, 1, 0, 0,      AE1, 0, 0));
        vecs.push_back(mk(1, 0, AE2, 0, 4'b0010, 4'b0000, 0, 0, 0, D_RAM, AE1, 0, 0));
        vecs.push_back(mk(1, 0, AE2, 0, 4'b0010, 4'b0010, 0, 0, 0, D_RAM, AE2, 0, 0));
        vecs.push_back(mk(1, 0, AE2, 0, 4'b0010, 4'b0010, 1, 1, 0, D_RAM, AE2, 0, 0));
        // Unmapped write to slot 4: error, read word untouched
        vecs.push_back(mk(1, 1, AF, 32'h5A, 4'b1111, 4'b0000, 0, 0, 0, D_GPIO, AE2, 0, 0));
        vecs.push_back(mk(1, 1, AF, 32'h5A, 4'b1111, 4'b0000, 0, 0, 0, D_GPIO, AF,  1, 32'h5A));
        vecs.push_back(mk(1, 1, AF, 32'h5A, 4'b1111, 4'b0000, 1, 1, 1, D_GPIO, AF,  1, 32'h5A));
        // RAM read timeout (TIMEOUT=4), transfer dropped and address changed mid-access
        vecs.push_back(mk(1, 0, AD, 0, 4'b1110, 4'b0000, 0, 0, 0, D_GPIO, AF, 1, 32'h5A));
        vecs.push_back(mk(1, 0, AD, 0, 4'b1110, 4'b0001, 0, 0, 0, D_GPIO, AD, 0, 0));
        vecs.push_back(mk(1, 0, AD, 0, 4'b1110, 4'b0001, 1, 0, 0, D_GPIO, AD, 0, 0));
        vecs.push_back(mk(0, 0, AD, 0, 4'b1110, 4'b0001, 1, 0, 0, D_GPIO, AD, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 4'b1110, 4'b0001, 1, 0, 0, D_GPIO, AD, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 4'b1110, 4'b0001, 1, 1, 1, D_GPIO, AD, 0, 0));
        // Idle afterwards
        vecs.push_back(mk(0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0, 0, 0,      AD, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 4'b0000, 4'b0000, 0, 0, 0, 0,      AD, 0, 0));

        // Reset state
        #1;
        chk_all_zero("reset", 0);
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // Table replay: inputs applied just after the edge, outputs sampled on the falling edge
        foreach (vecs[i]) begin
            drive(vecs[i].tr, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].prdy);
            @(negedge clk);
            chk("psel",   i, {28'd0, PSEL},    {28'd0, vecs[i].psel});
            chk("penable",i, {31'd0, PENABLE}, {31'd0, vecs[i].pen});
            chk("ready",  i, {31'd0, ready},   {31'd0, vecs[i].rdy});
            chk("busErr", i, {31'd0, busErr},  {31'd0, vecs[i].err});
            chk("rdata",  i, busRData,         vecs[i].rdata);
            chk("paddr",  i, PADDR,            vecs[i].paddr);
            chk("pwrite", i, {31'd0, PWRITE},  {31'd0, vecs[i].pwr});
            chk("pwdata", i, PWDATA,           vecs[i].pwd);
            next_cycle();
        end

        // Reset asserted in ACCESS aborts immediately
        drive(1'b1, 1'b0, AE1, 32'h77, 4'b0000);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("abort_psel_pre", 100, {28'd0, PSEL}, 32'h0000_0001);
        chk("abort_pen_pre",  100, {31'd0, PENABLE}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("abort", 101);
        transfer = 1'b0;
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_abort_ready", 110 + k, {31'd0, ready}, 32'd0);
            chk("post_abort_psel",  110 + k, {28'd0, PSEL}, 32'd0);
            next_cycle();
        end

        // Recovery read from RAM
        drive(1'b1, 1'b0, AE1, 32'd0, 4'b0001);
        @(negedge clk);
        chk("rec_ready_c0", 120, {31'd0, ready}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rec_psel_c1", 121, {28'd0, PSEL}, 32'h0000_0001);
        next_cycle();
        @(negedge clk);
        chk("rec_ready_c2", 122, {31'd0, ready}, 32'd1);
        chk("rec_err_c2",   122, {31'd0, busErr}, 32'd0);
        next_cycle();
        transfer = 1'b0;
        @(negedge clk);
        chk("rec_rdata_c3", 123, busRData, D_RAM);
        chk("rec_ready_c3", 123, {31'd0, ready}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
